// File: rtl/unsign_sum_diff_decoder.sv
// Recovers operands A and B from a sum/difference pair (A = (S+D)/2, B = (S-D)/2).
// Flags pairs that do not decode to legal N-bit operands and keeps a saturating count of them.
module unsign_sum_diff_decoder #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [INPUT_BIT_WIDTH:0]     SumIn,
    input  logic [INPUT_BIT_WIDTH:0]     DiffIn,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [INPUT_BIT_WIDTH-1:0]   ResultA,
    output logic [INPUT_BIT_WIDTH-1:0]   ResultB,
    output logic                         ResultErr,
    output logic [ERR_COUNT_WIDTH-1:0]   ErrCount
);
    localparam int N = INPUT_BIT_WIDTH;

    // state | meaning
    // IDLE  | ready for a pair; captures S/D when InValid
    // CALC  | phase 0 computes tA/tB, phase 1 registers results and error flag
    // DONE  | result presented; leaves on OutReady
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       phase_q, phase_d;
    logic [N:0]                 sum_q, sum_d;
    logic [N:0]                 diff_q, diff_d;
    logic [N+2:0]               ta_q, ta_d;
    logic [N+2:0]               tb_q, tb_d;
    logic [N-1:0]               res_a_q, res_a_d;
    logic [N-1:0]               res_b_q, res_b_d;
    logic                       res_err_q, res_err_d;
    logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                       calc_err;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            sum_q     <= '0;
            diff_q    <= '0;
            ta_q      <= '0;
            tb_q      <= '0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            res_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sum_q     <= sum_d;
            diff_q    <= diff_d;
            ta_q      <= ta_d;
            tb_q      <= tb_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            res_err_q <= res_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    state_d = S_CALC;
                    phase_d = 1'b0;
                end
            end
            S_CALC: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    phase_d = 1'b0;
                end
            end
            S_DONE: begin
                if (OutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Odd tA means S and D disagree in parity; nonzero top bits mean an operand is negative or too wide.
    always_comb begin
        sum_d     = sum_q;
        diff_d    = diff_q;
        ta_d      = ta_q;
        tb_d      = tb_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        res_err_d = res_err_q;
        err_cnt_d = err_cnt_q;
        calc_err  = ta_q[0] | (|ta_q[N+2:N+1]) | (|tb_q[N+2:N+1]);
        if (state_q == S_IDLE && InValid) begin
            sum_d  = SumIn;
            diff_d = DiffIn;
        end
        if (state_q == S_CALC && !phase_q) begin
            ta_d = {2'b00, sum_q} + {{2{diff_q[N]}}, diff_q};
            tb_d = {2'b00, sum_q} - {{2{diff_q[N]}}, diff_q};
        end
        if (state_q == S_CALC && phase_q) begin
            res_err_d = calc_err;
            res_a_d   = calc_err ? '0 : ta_q[N:1];
            res_b_d   = calc_err ? '0 : tb_q[N:1];
            if (calc_err && err_cnt_q != {ERR_COUNT_WIDTH{1'b1}})
                err_cnt_d = err_cnt_q + ERR_COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_DONE);
    end

    assign ResultA   = res_a_q;
    assign ResultB   = res_b_q;
    assign ResultErr = res_err_q;
    assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_unsign_sum_diff_decoder.sv
// Directed bench for unsign_sum_diff_decoder with N=8: decode values, latency,
// error counting and saturation, backpressure and asynchronous reset.
module tb_unsign_sum_diff_decoder;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       InValid;
    logic       InReady;
    logic [8:0] SumIn;
    logic [8:0] DiffIn;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] ResultA;
    logic [7:0] ResultB;
    logic       ResultErr;
    logic [7:0] ErrCount;

    int checks = 0;
    int errors = 0;
    int cnt_exp = 0;

    unsign_sum_diff_decoder #(.INPUT_BIT_WIDTH(8), .ERR_COUNT_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .SumIn(SumIn), .DiffIn(DiffIn), .OutValid(OutValid), .OutReady(OutReady),
        .ResultA(ResultA), .ResultB(ResultB), .ResultErr(ResultErr), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Presents a pair at a negedge and returns 1ns after the accepting edge.
    task automatic send(input logic [8:0] s, input logic [8:0] d);
        int n = 0;
        @(negedge Clk);
        SumIn = s;
        DiffIn = d;
        InValid = 1'b1;
        while (!InReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("send_ready", 32'(InReady), 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    // One transaction with OutReady high; checks latency, InReady-low length and results.
    task automatic run_pair(input string tag, input logic [8:0] s, input logic [8:0] d,
                            input int ea, input int eb, input int ee);
        int k = 0;
        int lat = -1;
        int low = 0;
        logic [7:0] ga = 8'h0;
        logic [7:0] gb = 8'h0;
        logic       ge = 1'b0;
        logic [7:0] gc = 8'h0;
        OutReady = 1'b1;
        send(s, d);
        if (ee != 0 && cnt_exp < 255) cnt_exp++;
        while (k < 12) begin
            if (OutValid && lat < 0) begin
                lat = k;
                ga = ResultA;
                gb = ResultB;
                ge = ResultErr;
                gc = ErrCount;
            end
            if (InReady) break;
            low++;
            @(posedge Clk);
            #1;
            k++;
        end
        check({tag, "_lat"}, 32'(lat), 2);
        check({tag, "_inready_low"}, 32'(low), 3);
        check({tag, "_a"}, 32'(ga), 32'(ea));
        check({tag, "_b"}, 32'(gb), 32'(eb));
        check({tag, "_err"}, 32'(ge), 32'(ee));
        check({tag, "_cnt"}, 32'(gc), 32'(cnt_exp));
    endtask

    initial begin
        int n;
        int seen;
        Reset = 1'b1;
        InValid = 1'b0;
        OutReady = 1'b1;
        SumIn = '0;
        DiffIn = '0;
        #12;
        check("rst_inready", 32'(InReady), 1);
        check("rst_outvalid", 32'(OutValid), 0);
        check("rst_a", 32'(ResultA), 0);
        check("rst_cnt", 32'(ErrCount), 0);
        @(negedge Clk);
        Reset = 1'b0;

        run_pair("basic", 9'd13, 9'd5, 9, 4, 0);
        run_pair("negdiff", 9'd253, 9'h109, 3, 250, 0);
        run_pair("max", 9'h1FE, 9'd0, 255, 255, 0);
        run_pair("a0b255", 9'd255, 9'h101, 0, 255, 0);
        run_pair("zero", 9'd0, 9'd0, 0, 0, 0);
        run_pair("odd", 9'd4, 9'd1, 0, 0, 1);
        run_pair("bneg", 9'd2, 9'h0FE, 0, 0, 1);
        run_pair("aover", 9'h1FF, 9'h0FF, 0, 0, 1);
        for (int i = 0; i < 300; i++) run_pair("sat", 9'd4, 9'd1, 0, 0, 1);
        check("sat_final", 32'(ErrCount), 255);
        run_pair("sat_good", 9'd13, 9'd5, 9, 4, 0);

        // Backpressure: result held while a new pair waits.
        OutReady = 1'b0;
        send(9'd13, 9'd5);
        n = 0;
        while (!OutValid && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("bp_valid", 32'(OutValid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            SumIn = 9'h1FE;
            DiffIn = 9'd0;
            InValid = (i % 2) == 0;
            @(posedge Clk);
            #1;
            check("bp_hold_valid", 32'(OutValid), 1);
            check("bp_hold_ready", 32'(InReady), 0);
            check("bp_hold_a", 32'(ResultA), 9);
            check("bp_hold_b", 32'(ResultB), 4);
        end
        @(negedge Clk);
        InValid = 1'b1;
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        check("bp_release_idle", 32'(InReady), 1);
        check("bp_release_novalid", 32'(OutValid), 0);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("bp_new_accepted", 32'(InReady), 0);
        n = 0;
        while (!OutValid && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("bp_new_lat", 32'(n), 2);
        check("bp_new_a", 32'(ResultA), 255);
        check("bp_new_b", 32'(ResultB), 255);

        // Reset mid-CALC.
        @(posedge Clk);
        #1;
        send(9'd13, 9'd5);
        #3;
        Reset = 1'b1;
        #1;
        check("rcalc_inready", 32'(InReady), 1);
        check("rcalc_outvalid", 32'(OutValid), 0);
        check("rcalc_a", 32'(ResultA), 0);
        check("rcalc_b", 32'(ResultB), 0);
        check("rcalc_cnt", 32'(ErrCount), 0);
        cnt_exp = 0;
        @(negedge Clk);
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            if (OutValid) seen++;
        end
        check("rcalc_no_stale", 32'(seen), 0);

        // Reset mid-DONE with the result stalled.
        OutReady = 1'b0;
        send(9'd4, 9'd1);
        n = 0;
        while (!OutValid && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("rdone_err_before", 32'(ResultErr), 1);
        #3;
        Reset = 1'b1;
        #1;
        check("rdone_inready", 32'(InReady), 1);
        check("rdone_outvalid", 32'(OutValid), 0);
        check("rdone_err", 32'(ResultErr), 0);
        check("rdone_cnt", 32'(ErrCount), 0);
        @(negedge Clk);
        Reset = 1'b0;
        OutReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            if (OutValid) seen++;
        end
        check("rdone_no_stale", 32'(seen), 0);
        run_pair("post_reset", 9'd13, 9'd5, 9, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
